// File: rtl/booth_seq_mul_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_t  : FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   MODE_*   : operand interpretation selected by mode_sgn
package booth_seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_UNS = 1'b0;
    localparam logic MODE_SGN = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on {acc, q, q_m1}, N bits per register.
//   acc, q, q_m1 : current partial state
//   mcand        : multiplicand (already extended to N bits)
//   *_nxt        : state after the add/sub and the arithmetic right shift
// The add/sub is done one bit wider than acc so the shift always sees the
// true sign of the sum, whatever the operand values.
module booth_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N-1:0] mcand,
    output logic [N-1:0] acc_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q_m1_nxt
);

    logic [N:0] acc_ext;
    logic [N:0] mcand_ext;
    logic [N:0] sum;

    always_comb begin
        acc_ext   = {acc[N-1], acc};
        mcand_ext = {mcand[N-1], mcand};
        case ({q[0], q_m1})
            2'b10:   sum = acc_ext - mcand_ext;
            2'b01:   sum = acc_ext + mcand_ext;
            default: sum = acc_ext;
        endcase
        // Arithmetic shift right by one across {sum, q, q_m1}.
        acc_nxt  = sum[N:1];
        q_nxt    = {sum[0], q[N-1:1]};
        q_m1_nxt = q[0];
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, signed or unsigned at runtime.
//   clk, CLR            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, mode_sgn)
//   out_valid/out_ready : result handshake (product, result, overflow)
//   product             : full 2W-bit product
//   result              : W-bit truncated (SAT=0) or saturated (SAT=1) product
//   overflow            : product does not fit W bits in the latched mode
//   dbg_state           : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data until that edge; ready never
// depends on valid. in_ready is high exactly in IDLE, out_valid exactly in
// DONE, and data outputs hold steady while out_valid is high.
module booth_seq_mul
    import booth_seq_mul_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_sgn,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic [W-1:0]     result,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(W + 2);

    state_t            state_q,    state_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [W:0]        acc_q,      acc_d;
    logic [W:0]        mq_q,       mq_d;
    logic              qm1_q,      qm1_d;
    logic [W:0]        mcand_q,    mcand_d;
    logic              mode_q,     mode_d;
    logic [2*W-1:0]    product_q,  product_d;
    logic [W-1:0]      result_q,   result_d;
    logic              overflow_q, overflow_d;

    logic [W:0]        step_acc;
    logic [W:0]        step_q;
    logic              step_qm1;
    logic [2*W-1:0]    prod_new;
    logic              ovf_new;
    logic              unused_acc_top;

    booth_step #(.N(W + 1)) u_step (
        .acc      (acc_q),
        .q        (mq_q),
        .q_m1     (qm1_q),
        .mcand    (mcand_q),
        .acc_nxt  (step_acc),
        .q_nxt    (step_q),
        .q_m1_nxt (step_qm1)
    );

    // The W+1 x W+1 product is 2W+2 bits; its top two bits are redundant
    // because both operand kinds fit in 2W bits.
    assign prod_new       = {step_acc[W-2:0], step_q};
    assign unused_acc_top = ^step_acc[W:W-1];

    always_comb begin
        if (mode_q == MODE_SGN)
            ovf_new = !((&prod_new[2*W-1:W-1]) || !(|prod_new[2*W-1:W-1]));
        else
            ovf_new = |prod_new[2*W-1:W];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        qm1_d      = qm1_q;
        mcand_d    = mcand_q;
        mode_d     = mode_q;
        product_d  = product_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d  = mode_sgn;
                    mcand_d = {(mode_sgn == MODE_SGN) ? a[W-1] : 1'b0, a};
                    mq_d    = {(mode_sgn == MODE_SGN) ? b[W-1] : 1'b0, b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(W + 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                mq_d  = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = ST_DONE;
                    product_d  = prod_new;
                    overflow_d = ovf_new;
                    if (SAT && ovf_new) begin
                        if (mode_q == MODE_UNS)
                            result_d = {W{1'b1}};
                        else if (prod_new[2*W-1])
                            result_d = {1'b1, {(W-1){1'b0}}};
                        else
                            result_d = {1'b0, {(W-1){1'b1}}};
                    end else begin
                        result_d = prod_new[W-1:0];
                    end
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            qm1_q      <= 1'b0;
            mcand_q    <= '0;
            mode_q     <= MODE_UNS;
            product_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            qm1_q      <= qm1_d;
            mcand_q    <= mcand_d;
            mode_q     <= mode_d;
            product_q  <= product_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = product_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
module tb_booth_seq_mul;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // W=8 pair (SAT=0 and SAT=1) share inputs
    logic        clr8, in_valid8, mode8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready0, out_valid0, overflow0, in_ready1, out_valid1, overflow1;
    logic [15:0] product0, product1;
    logic [7:0]  result0, result1;
    logic [1:0]  dbg0, dbg1;

    // W=13, SAT=1
    logic        clr13, in_valid13, mode13, out_ready13;
    logic [12:0] a13, b13;
    logic        in_ready2, out_valid2, overflow2;
    logic [25:0] product2;
    logic [12:0] result2;
    logic [1:0]  dbg2;

    booth_seq_mul #(.W(8), .SAT(1'b0)) dut0 (
        .clk(clk), .CLR(clr8), .in_valid(in_valid8), .in_ready(in_ready0),
        .mode_sgn(mode8), .a(a8), .b(b8), .out_valid(out_valid0),
        .out_ready(out_ready8), .product(product0), .result(result0),
        .overflow(overflow0), .dbg_state(dbg0));

    booth_seq_mul #(.W(8), .SAT(1'b1)) dut1 (
        .clk(clk), .CLR(clr8), .in_valid(in_valid8), .in_ready(in_ready1),
        .mode_sgn(mode8), .a(a8), .b(b8), .out_valid(out_valid1),
        .out_ready(out_ready8), .product(product1), .result(result1),
        .overflow(overflow1), .dbg_state(dbg1));

    booth_seq_mul #(.W(13), .SAT(1'b1)) dut2 (
        .clk(clk), .CLR(clr13), .in_valid(in_valid13), .in_ready(in_ready2),
        .mode_sgn(mode13), .a(a13), .b(b13), .out_valid(out_valid2),
        .out_ready(out_ready13), .product(product2), .result(result2),
        .overflow(overflow2), .dbg_state(dbg2));

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiplication and range tests.
    function automatic void ref_mul(input int w, input bit sgn, input bit sat,
                                    input longint unsigned av, input longint unsigned bv,
                                    output longint unsigned prod, output longint unsigned res,
                                    output bit ovf);
        longint full, half, sa, sb, p;
        full = longint'(1) << w;
        half = full >> 1;
        sa = (sgn && longint'(av) >= half) ? longint'(av) - full : longint'(av);
        sb = (sgn && longint'(bv) >= half) ? longint'(bv) - full : longint'(bv);
        p = sa * sb;
        prod = longint'(p) & ((full * full) - 1);
        if (sgn) ovf = (p > half - 1) || (p < -half);
        else     ovf = (p > full - 1);
        if (sat && ovf) res = sgn ? ((p > 0) ? half - 1 : half) : full - 1;
        else            res = longint'(p) & (full - 1);
    endfunction

    // ---------------- drivers ----------------
    // Runs one W=8 operation; holds out_ready low for 'hold' cycles after out_valid.
    task automatic run8(input bit sgn, input logic [7:0] av, input logic [7:0] bv, input int hold,
                        output logic [15:0] p0, output logic [7:0] r0, output logic o0,
                        output logic [15:0] p1, output logic [7:0] r1, output logic o1,
                        output int lat, output logic v1);
        int n;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        mode8 = sgn; a8 = av; b8 = bv; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid0 && lat < 40);
        v1 = out_valid1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        p0 = product0; r0 = result0; o0 = overflow0;
        p1 = product1; r1 = result1; o1 = overflow1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run13(input bit sgn, input logic [12:0] av, input logic [12:0] bv,
                         output logic [25:0] p, output logic [12:0] r, output logic o,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        mode13 = sgn; a13 = av; b13 = bv; in_valid13 = 1'b1;
        @(posedge clk); #1;
        in_valid13 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid2 && lat < 40);
        p = product2; r = result2; o = overflow2;
        out_ready13 = 1'b1;
        @(posedge clk); #1;
        out_ready13 = 1'b0;
    endtask

    // ---------------- test vectors ----------------
    typedef struct {
        bit          sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic [7:0]  res0;
        logic [7:0]  res1;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];
    logic [32:0] exp_q[$];

    initial begin
        logic [15:0] p0, p1;
        logic [7:0]  r0, r1;
        logic        o0, o1, v1;
        logic [25:0] p13;
        logic [12:0] r13;
        logic        o13;
        int          lat;
        longint unsigned ep, er0, er1;
        bit          eo, eo1;
        logic [32:0] exp_e;
        logic [12:0] edge13[4];

        vecs[0]  = '{1'b1, 8'hFE, 8'h0F, 16'hFFE2, 8'hE2, 8'hE2, 1'b0};
        vecs[1]  = '{1'b1, 8'h0C, 8'h0E, 16'h00A8, 8'hA8, 8'h7F, 1'b1};
        vecs[2]  = '{1'b0, 8'h0C, 8'h0E, 16'h00A8, 8'hA8, 8'hA8, 1'b0};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 8'h00, 8'h7F, 1'b1};
        vecs[4]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h01, 8'hFF, 1'b1};
        vecs[5]  = '{1'b1, 8'h80, 8'h01, 16'hFF80, 8'h80, 8'h80, 1'b0};
        vecs[6]  = '{1'b1, 8'h80, 8'hFF, 16'h0080, 8'h80, 8'h7F, 1'b1};
        vecs[7]  = '{1'b1, 8'h7F, 8'h02, 16'h00FE, 8'hFE, 8'h7F, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 8'h01, 8'h01, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 8'hFF, 16'h0000, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'h81, 8'h7F, 16'hC0FF, 8'hFF, 8'h80, 1'b1};

        clr8 = 1'b1; in_valid8 = 1'b0; mode8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        clr13 = 1'b1; in_valid13 = 1'b0; mode13 = 1'b0; out_ready13 = 1'b0; a13 = '0; b13 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {in_ready0, in_ready1, in_ready2}, 3'b111);
        chk("rst_out_valid", {out_valid0, out_valid1, out_valid2}, 3'b000);
        chk("rst_product", {product0, product1, product2}, '0);
        chk("rst_result_ovf", {result0, result1, result2, overflow0, overflow1, overflow2}, '0);
        clr8 = 1'b0; clr13 = 1'b0;

        // Directed table: both SAT variants from one launch
        foreach (vecs[i]) begin
            run8(vecs[i].sgn, vecs[i].a, vecs[i].b, i % 3, p0, r0, o0, p1, r1, o1, lat, v1);
            chk($sformatf("tbl%0d_latency", i), lat, 9);
            chk($sformatf("tbl%0d_sat1_valid", i), v1, 1'b1);
            chk($sformatf("tbl%0d_product", i), {p0, p1}, {vecs[i].prod, vecs[i].prod});
            chk($sformatf("tbl%0d_result_sat0", i), r0, vecs[i].res0);
            chk($sformatf("tbl%0d_result_sat1", i), r1, vecs[i].res1);
            chk($sformatf("tbl%0d_overflow", i), {o0, o1}, {vecs[i].ovf, vecs[i].ovf});
        end

        // Backpressure: outputs hold, busy input ignored, then release
        mode8 = 1'b1; a8 = 8'h0C; b8 = 8'h0E; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid0 && lat < 40);
        chk("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            mode8 = 1'b0; a8 = 8'h03; b8 = 8'h03; in_valid8 = (i % 2 == 0);
            chk($sformatf("bp_hold%0d", i),
                {out_valid0, in_ready0, product0, result0, overflow0, result1},
                {1'b1, 1'b0, 16'h00A8, 8'hA8, 1'b1, 8'h7F});
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        chk("bp_release_cycle", {out_valid0, in_ready0}, 2'b10);
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("bp_after_release", {out_valid0, in_ready0, product0, result0}, {1'b0, 1'b1, 16'h00A8, 8'hA8});
        repeat (3) @(posedge clk);
        #1;
        chk("bp_idle_stays", {out_valid0, in_ready0, product0}, {1'b0, 1'b1, 16'h00A8});

        // Reset in the 4th CALC cycle discards the operation
        mode8 = 1'b0; a8 = 8'h55; b8 = 8'h33; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("clr_pre_busy", {in_ready0, out_valid0}, 2'b00);
        clr8 = 1'b1;
        @(posedge clk); #1;
        clr8 = 1'b0;
        chk("clr_state", {in_ready0, out_valid0, in_ready1, out_valid1}, 4'b1010);
        chk("clr_outputs", {product0, result0, overflow0, product1, result1, overflow1}, '0);
        repeat (12) @(posedge clk);
        #1;
        chk("clr_no_ghost", out_valid0, 1'b0);
        run8(1'b0, 8'd7, 8'd5, 0, p0, r0, o0, p1, r1, o1, lat, v1);
        chk("clr_fresh_latency", lat, 9);
        chk("clr_fresh_product", {p0, r0, o0}, {16'd35, 8'd35, 1'b0});

        // Random sweep, W=8, through the expected queue
        for (int i = 0; i < 1500; i++) begin
            bit       s;
            logic [7:0] ra, rb;
            s  = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ref_mul(8, s, 1'b0, ra, rb, ep, er0, eo);
            ref_mul(8, s, 1'b1, ra, rb, ep, er1, eo1);
            exp_q.push_back({ep[15:0], er0[7:0], er1[7:0], eo});
            run8(s, ra, rb, $urandom_range(0, 2), p0, r0, o0, p1, r1, o1, lat, v1);
            exp_e = exp_q.pop_front();
            chk($sformatf("rnd8_%0d s=%0d a=%0h b=%0h", i, s, ra, rb), {p0, r0, r1, o0}, exp_e);
            if (lat != 9 || p1 !== p0 || o1 !== o0) chk($sformatf("rnd8_%0d_lat_pair", i), {lat, p1, o1}, {32'd9, p0, o0});
        end

        // W=13: edges then random
        edge13[0] = 13'h1000; edge13[1] = 13'h1FFF; edge13[2] = 13'h0000; edge13[3] = 13'h0FFF;
        for (int i = 0; i < 16; i++) begin
            bit s;
            s = (i >= 8);
            ref_mul(13, s, 1'b1, edge13[i % 4], edge13[(i / 4) % 4], ep, er1, eo);
            run13(s, edge13[i % 4], edge13[(i / 4) % 4], p13, r13, o13, lat);
            chk($sformatf("edge13_%0d", i), {lat, p13, r13, o13}, {32'd14, ep[25:0], er1[12:0], eo});
        end
        for (int i = 0; i < 1200; i++) begin
            bit s;
            logic [12:0] ra, rb;
            s  = 1'($urandom_range(0, 1));
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            ref_mul(13, s, 1'b1, ra, rb, ep, er1, eo);
            run13(s, ra, rb, p13, r13, o13, lat);
            chk($sformatf("rnd13_%0d s=%0d a=%0h b=%0h", i, s, ra, rb),
                {lat, p13, r13, o13}, {32'd14, ep[25:0], er1[12:0], eo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
